tcb_lib_memory_responder: RTL and testbench

- TCB subordinate (responder) end of the bus: accepts manager transfers, services them from an internal byte-addressable RAM, and returns read data and status a fixed DLY cycles after each handshake.
- Sits wherever a TCB manager or passthrough needs a real target. It is the synthesizable counterpart to the manager-side write/read sequences, and is the standard endpoint in library block benches.

---
 rtl/tcb_lib_memory_responder.sv | 193 +++++++++++++++++++
 tb/tb_tcb_lib_memory_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tcb_lib_memory_responder.sv
// TCB responder backed by a byte-addressable RAM.
// Each accepted transfer (trn = tcb_vld & tcb_rdy) gets its response DLY cycles later.
// After every accepted transfer, tcb_rdy drops for STL cycles.
//
// Optional build macro: TCB_LIB_MEMORY_RESPONDER_ERR_EN
//   defined   : out-of-range or misaligned requests respond with err=1 and rdt=0.
//               Such requests never write the RAM.
//   undefined : tcb_err is tied 0, addresses wrap modulo SIZ, lane alignment is ignored.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   tcb_vld    request valid           tcb_rdy  request ready (registered)
//   tcb_wen    1=write / 0=read        tcb_adr  byte address [ABW]
//   tcb_ben    byte enables [DBW/8]    tcb_wdt  write data [DBW]
//   tcb_rdt    read data [DBW]         tcb_err  error status, aligned with tcb_rdt
module tcb_lib_memory_responder #(
    parameter int unsigned ABW = 32,
    parameter int unsigned DBW = 32,
    parameter int unsigned DLY = 1,
    parameter int unsigned SIZ = 1024,
    parameter int unsigned STL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tcb_vld,
    output logic             tcb_rdy,
    input  logic             tcb_wen,
    input  logic [ABW-1:0]   tcb_adr,
    input  logic [DBW/8-1:0] tcb_ben,
    input  logic [DBW-1:0]   tcb_wdt,
    output logic [DBW-1:0]   tcb_rdt,
    output logic             tcb_err
);

    localparam int unsigned BEW = DBW / 8;
    localparam int unsigned OFS = $clog2(BEW);
    localparam int unsigned OFW = (OFS > 0) ? OFS : 1;
    localparam int unsigned MAW = $clog2(SIZ);
    localparam int unsigned IDW = MAW - OFS;
    localparam int unsigned DEP = SIZ / BEW;
    localparam int unsigned CNW = 3;

    typedef enum logic {
        ST_READY,
        ST_WAIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNW-1:0]   cnt;
    logic [CNW-1:0]   cnt_nxt;

    logic             trn;
    logic             req_err;
    logic [IDW-1:0]   idx;
    logic [DBW-1:0]   ben_mask;
    logic [DBW-1:0]   rsp_rdt;
    logic             rsp_err;

    logic [DBW-1:0]   mem      [DEP];
    logic [DBW-1:0]   pipe_rdt [DLY];
    logic             pipe_err [DLY];

    assign trn = tcb_vld & tcb_rdy;
    // Upper address bits are dropped here, which makes addresses wrap modulo SIZ.
    assign idx = tcb_adr[MAW-1:OFS];

    // Expand byte enables to a bit mask.
    always_comb begin
        ben_mask = '0;
        for (int i = 0; i < int'(BEW); i++) begin
            ben_mask[8*i +: 8] = {8{tcb_ben[i]}};
        end
    end

`ifdef TCB_LIB_MEMORY_RESPONDER_ERR_EN
    logic [OFW-1:0] adr_lo;
    logic [OFW-1:0] lo_idx;
    logic           lo_fnd;
    logic           gap;
    logic           split;

    assign adr_lo = OFW'(tcb_adr & ABW'(BEW - 1));

    // Error on an out-of-range address, or when the enabled lanes do not start at
    // the address offset, or when the enabled lanes are not contiguous.
    always_comb begin
        lo_fnd = 1'b0;
        lo_idx = '0;
        gap    = 1'b0;
        split  = 1'b0;
        for (int i = 0; i < int'(BEW); i++) begin
            if (tcb_ben[i]) begin
                if (!lo_fnd) begin
                    lo_fnd = 1'b1;
                    lo_idx = OFW'(i);
                end else if (gap) begin
                    split = 1'b1;
                end
            end else if (lo_fnd) begin
                gap = 1'b1;
            end
        end
        req_err = ((tcb_adr >> MAW) != '0) || (lo_fnd && ((lo_idx != adr_lo) || split));
    end
`else
    logic unused_adr;
    assign unused_adr = ^tcb_adr;
    assign req_err    = 1'b0;
`endif

    // RAM write; lane-masked, suppressed on error and during reset.
    always_ff @(posedge clk) begin
        if (!rst && trn && tcb_wen && !req_err) begin
            for (int i = 0; i < int'(BEW); i++) begin
                if (tcb_ben[i]) begin
                    mem[idx][8*i +: 8] <= tcb_wdt[8*i +: 8];
                end
            end
        end
    end

    // Stage-1 input. A bubble keeps the previous data so the outputs stay stable.
    always_comb begin
        rsp_rdt = pipe_rdt[0];
        rsp_err = 1'b0;
        if (trn) begin
            rsp_err = req_err;
            rsp_rdt = (!tcb_wen && !req_err) ? (mem[idx] & ben_mask) : '0;
        end
    end

    // Response delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DLY; i++) begin
                pipe_rdt[i] <= '0;
                pipe_err[i] <= 1'b0;
            end
        end else begin
            pipe_rdt[0] <= rsp_rdt;
            pipe_err[0] <= rsp_err;
            for (int unsigned i = 1; i < DLY; i++) begin
                pipe_rdt[i] <= pipe_rdt[i-1];
                pipe_err[i] <= pipe_err[i-1];
            end
        end
    end

    assign tcb_rdt = pipe_rdt[DLY-1];
    assign tcb_err = pipe_err[DLY-1];

    // Stall FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_READY;
            cnt     <= '0;
            tcb_rdy <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tcb_rdy <= (state_nxt == ST_READY);
        end
    end

    // Stall FSM: next state. The count is loaded with STL and exits WAIT at 1,
    // which gives exactly STL low cycles of rdy.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_READY: begin
                if (trn && (STL != 0)) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNW'(STL);
                end
            end
            ST_WAIT: begin
                if (cnt <= CNW'(1)) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CNW'(1);
                end
            end
            default: begin
                state_nxt = ST_READY;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tcb_lib_memory_responder.sv
// Bench for tcb_lib_memory_responder.
// Three instances are used: (DLY=1,STL=0), (DLY=3,STL=0) and (DLY=2,STL=2).
// Expected responses are queued when a transfer is driven and compared at their due cycle.
module tb_tcb_lib_memory_responder;

    logic        clk = 1'b0;
    logic        rst    [3];
    logic        vld    [3];
    logic        rdy    [3];
    logic        wen    [3];
    logic [31:0] adr    [3];
    logic [3:0]  ben    [3];
    logic [31:0] wdt    [3];
    logic [31:0] rdt    [3];
    logic        err    [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] rdt;
        logic        err;
    } sb_t;

    sb_t sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tcb_lib_memory_responder #(.ABW(32), .DBW(32), .DLY(1), .SIZ(1024), .STL(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .tcb_vld(vld[0]), .tcb_rdy(rdy[0]), .tcb_wen(wen[0]),
        .tcb_adr(adr[0]), .tcb_ben(ben[0]), .tcb_wdt(wdt[0]), .tcb_rdt(rdt[0]), .tcb_err(err[0]));

    tcb_lib_memory_responder #(.ABW(32), .DBW(32), .DLY(3), .SIZ(1024), .STL(0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .tcb_vld(vld[1]), .tcb_rdy(rdy[1]), .tcb_wen(wen[1]),
        .tcb_adr(adr[1]), .tcb_ben(ben[1]), .tcb_wdt(wdt[1]), .tcb_rdt(rdt[1]), .tcb_err(err[1]));

    tcb_lib_memory_responder #(.ABW(32), .DBW(32), .DLY(2), .SIZ(1024), .STL(2)) u_dut2 (
        .clk(clk), .rst(rst[2]), .tcb_vld(vld[2]), .tcb_rdy(rdy[2]), .tcb_wen(wen[2]),
        .tcb_adr(adr[2]), .tcb_ben(ben[2]), .tcb_wdt(wdt[2]), .tcb_rdt(rdt[2]), .tcb_err(err[2]));

    function automatic int dly_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_push(input int i, input logic [31:0] r, input logic e);
        sb_t s;
        s.inst = i;
        s.due  = cyc + dly_of(i);
        s.rdt  = r;
        s.err  = e;
        sbq.push_back(s);
    endtask

    // Called at a negedge; drives one request, waits for acceptance, ends one negedge later.
    task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] er, input logic ee, input bit push);
        int n;
        n = 0;
        vld[i] = 1'b1; wen[i] = w; adr[i] = a; ben[i] = b; wdt[i] = d;
        while (rdy[i] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("rdy_wait", 64'(rdy[i]), 64'd1);
            vld[i] = 1'b0;
            return;
        end
        if (push) sb_push(i, er, ee);
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    // Non-transfer cycle: outputs must keep the last data with err=0.
    task automatic idle(input int i, input logic [31:0] er);
        sb_push(i, er, 1'b0);
        @(negedge clk);
    endtask

    // Scoreboard: compare each queued response on its due cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            sb_t s;
            s = sbq.pop_front();
            chk($sformatf("rdt[%0d]@%0d", s.inst, s.due), 64'(rdt[s.inst]), 64'(s.rdt));
            chk($sformatf("err[%0d]@%0d", s.inst, s.due), 64'(err[s.inst]), 64'(s.err));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_acc;
        int n;
        logic [31:0] e400, ew401, e_r0, e_b6;
        logic        f400, f401, f_b6;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; vld[i] = 1'b0; wen[i] = 1'b0;
            adr[i] = '0; ben[i] = '0; wdt[i] = '0;
        end

`ifdef TCB_LIB_MEMORY_RESPONDER_ERR_EN
        e_b6 = 32'h0;        f_b6 = 1'b1;
        e400 = 32'h0;        f400 = 1'b1;
        ew401 = 32'h0;       f401 = 1'b1;
        e_r0 = 32'h11223344;
`else
        e_b6 = 32'h00FFFF00; f_b6 = 1'b0;
        e400 = 32'h11223344; f400 = 1'b0;
        ew401 = 32'h0;       f401 = 1'b0;
        e_r0 = 32'hDEADBEEF;
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_rdy%0d", i), 64'(rdy[i]), 64'd0);
            chk($sformatf("rst_rdt%0d", i), 64'(rdt[i]), 64'd0);
            chk($sformatf("rst_err%0d", i), 64'(err[i]), 64'd0);
        end
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clk);
        chk("rel_rdy0", 64'(rdy[0]), 64'd1);
        chk("rel_rdy1", 64'(rdy[1]), 64'd1);

        // DLY=1: full write then back-to-back read of the same word
        xfer(0, 1'b1, 32'h4, 4'hF, 32'h76543210, 32'h0, 1'b0, 1'b1);
        xfer(0, 1'b0, 32'h4, 4'hF, 32'h0, 32'h76543210, 1'b0, 1'b1);
        // Partial writes and masked reads
        xfer(0, 1'b1, 32'h8, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        xfer(0, 1'b1, 32'h8, 4'h1, 32'h000000AB, 32'h0, 1'b0, 1'b1);
        xfer(0, 1'b0, 32'h8, 4'hF, 32'h0, 32'hFFFFFFAB, 1'b0, 1'b1);
        xfer(0, 1'b0, 32'h8, 4'h6, 32'h0, e_b6, f_b6, 1'b1);
        // Out-of-range accesses
        xfer(0, 1'b1, 32'h0, 4'hF, 32'h11223344, 32'h0, 1'b0, 1'b1);
        xfer(0, 1'b0, 32'h400, 4'hF, 32'h0, e400, f400, 1'b1);
        xfer(0, 1'b1, 32'h401, 4'hF, 32'hDEADBEEF, ew401, f401, 1'b1);
        xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, e_r0, 1'b0, 1'b1);
        idle(0, e_r0);
        idle(0, e_r0);

        // DLY=3: back-to-back writes then back-to-back reads
        for (int k = 0; k < 4; k++) xfer(1, 1'b1, 32'(4*k), 4'hF, 32'(k+1), 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) xfer(1, 1'b0, 32'(4*k), 4'hF, 32'h0, 32'(k+1), 1'b0, 1'b1);
        idle(1, 32'd4);

        // STL=2: vld held for six cycles gives rdy 1,0,0,1,0,0
        n_acc = 0;
        vld[2] = 1'b1; wen[2] = 1'b1; adr[2] = 32'h10; ben[2] = 4'hF; wdt[2] = 32'h5A5A5A5A;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("stl_rdy%0d", k), 64'(rdy[2]), (k % 3 == 0) ? 64'd1 : 64'd0);
            if (rdy[2] === 1'b1) begin
                n_acc++;
                sb_push(2, 32'h0, 1'b0);
            end
            @(negedge clk);
        end
        vld[2] = 1'b0;
        chk("stl_acc", 64'(n_acc), 64'd2);

        // Reset one cycle after a read: the pending response must be discarded
        xfer(2, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        xfer(2, 1'b0, 32'h20, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
        rst[2] = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("mrst_rdt", 64'(rdt[2]), 64'd0);
        chk("mrst_err", 64'(err[2]), 64'd0);
        chk("mrst_rdy", 64'(rdy[2]), 64'd0);
        rst[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mrst_hold%0d", k), 64'(rdt[2]), 64'd0);
        end
        // RAM contents survive the reset
        xfer(2, 1'b0, 32'h20, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

        n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
